// File: rtl/fma_issue_ctrl.sv
// rtl/fma_issue_ctrl.sv - two-requester issue controller with special-case bypass and ordered result FIFO
module fma_issue_ctrl #(
    parameter int PARM_XLEN       = 32,
    parameter int PARM_EXP        = 8,
    parameter int PARM_MANT       = 23,
    parameter int PARM_PIPE_LAT   = 4,
    parameter int PARM_FIFO_DEPTH = 8,
    parameter int PARM_TAG        = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [1:0]               req_valid_i,
    output logic [1:0]               req_ready_o,
    input  logic [2*PARM_XLEN-1:0]   req_A_i,
    input  logic [2*PARM_XLEN-1:0]   req_B_i,
    input  logic [2*PARM_XLEN-1:0]   req_C_i,
    input  logic [2*PARM_TAG-1:0]    req_tag_i,
    output logic                     dp_valid_o,
    output logic [PARM_XLEN-1:0]     dp_A_o,
    output logic [PARM_XLEN-1:0]     dp_B_o,
    output logic [PARM_XLEN-1:0]     dp_C_o,
    input  logic [PARM_XLEN-1:0]     dp_result_i,
    output logic                     res_valid_o,
    input  logic                     res_ready_i,
    output logic [PARM_XLEN-1:0]     res_data_o,
    output logic [PARM_TAG-1:0]      res_tag_o,
    output logic                     res_src_o,
    output logic                     res_nv_o,
    output logic                     busy_o
);
    localparam int OW = $clog2(PARM_FIFO_DEPTH + 1);
    localparam int PW = (PARM_FIFO_DEPTH > 1) ? $clog2(PARM_FIFO_DEPTH) : 1;
    localparam int DL = PARM_PIPE_LAT;
    localparam logic [OW-1:0] OCC_MAX  = OW'(PARM_FIFO_DEPTH);
    localparam logic [OW-1:0] OCC_ONE  = OW'(1);
    localparam logic [PW-1:0] PTR_LAST = PW'(PARM_FIFO_DEPTH - 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PARM_XLEN-1:0] QNAN = {1'b0, {PARM_EXP{1'b1}}, 1'b1, {(PARM_MANT-1){1'b0}}};

    // Operand class bits: [3]=NaN [2]=sNaN [1]=Inf [0]=Zero
    function automatic logic [3:0] f_class(input logic [PARM_XLEN-1:0] x);
        logic exp_ones, exp_zero, frac_zero;
        exp_ones  = &x[PARM_XLEN-2 -: PARM_EXP];
        exp_zero  = ~|x[PARM_XLEN-2 -: PARM_EXP];
        frac_zero = ~|x[PARM_MANT-1:0];
        f_class = {exp_ones & ~frac_zero, exp_ones & ~frac_zero & ~x[PARM_MANT-1],
                   exp_ones & frac_zero, exp_zero & frac_zero};
    endfunction

    logic                 r_rr;
    logic [OW-1:0]        r_occ;
    logic [1:0]           w_grant;
    logic                 w_credit;
    logic                 w_accept;
    logic                 w_sel;
    logic                 w_pop;
    logic [PARM_XLEN-1:0] w_a, w_b, w_c;
    logic [PARM_TAG-1:0]  w_tag;
    logic [3:0]           w_cls_a, w_cls_b, w_cls_c;
    logic                 w_sign_p;
    logic                 w_special;
    logic [PARM_XLEN-1:0] w_spec_res;
    logic                 w_spec_nv;

    logic                 r_dp_valid;
    logic [PARM_XLEN-1:0] r_dp_a, r_dp_b, r_dp_c;

    logic [DL:0]          r_dl_valid;
    logic [DL:0]          r_dl_special;
    logic [DL:0]          r_dl_nv;
    logic [DL:0]          r_dl_src;
    logic [PARM_XLEN-1:0] r_dl_res [0:DL];
    logic [PARM_TAG-1:0]  r_dl_tag [0:DL];

    logic [PARM_XLEN-1:0]       r_mem_data [0:PARM_FIFO_DEPTH-1];
    logic [PARM_TAG-1:0]        r_mem_tag  [0:PARM_FIFO_DEPTH-1];
    logic [PARM_FIFO_DEPTH-1:0] r_mem_src;
    logic [PARM_FIFO_DEPTH-1:0] r_mem_nv;
    logic [PW-1:0]              r_wr_ptr, r_rd_ptr;
    logic [OW-1:0]              r_fifo_cnt;
    logic                       w_fifo_wr;
    logic [PARM_XLEN-1:0]       w_fifo_data;

    always_comb begin
        w_grant = 2'b00;
        case (req_valid_i)
            2'b01:   w_grant = 2'b01;
            2'b10:   w_grant = 2'b10;
            2'b11:   w_grant = r_rr ? 2'b10 : 2'b01;
            default: w_grant = 2'b00;
        endcase
    end

    assign w_credit    = (r_occ < OCC_MAX);
    assign req_ready_o = (rst_i || !w_credit) ? 2'b00 : w_grant;
    assign w_accept    = |(req_valid_i & req_ready_o);
    assign w_sel       = w_grant[1];

    assign w_a   = w_sel ? req_A_i[2*PARM_XLEN-1:PARM_XLEN] : req_A_i[PARM_XLEN-1:0];
    assign w_b   = w_sel ? req_B_i[2*PARM_XLEN-1:PARM_XLEN] : req_B_i[PARM_XLEN-1:0];
    assign w_c   = w_sel ? req_C_i[2*PARM_XLEN-1:PARM_XLEN] : req_C_i[PARM_XLEN-1:0];
    assign w_tag = w_sel ? req_tag_i[2*PARM_TAG-1:PARM_TAG] : req_tag_i[PARM_TAG-1:0];

    assign w_cls_a  = f_class(w_a);
    assign w_cls_b  = f_class(w_b);
    assign w_cls_c  = f_class(w_c);
    assign w_sign_p = w_a[PARM_XLEN-1] ^ w_b[PARM_XLEN-1];

    // Priority order matters: NaN beats invalid products, which beat Inf propagation.
    always_comb begin
        w_special  = 1'b1;
        w_spec_res = QNAN;
        w_spec_nv  = 1'b0;
        if (w_cls_a[3] | w_cls_b[3] | w_cls_c[3]) begin
            w_spec_nv = w_cls_a[2] | w_cls_b[2] | w_cls_c[2];
        end else if ((w_cls_a[1] & w_cls_b[0]) | (w_cls_a[0] & w_cls_b[1])) begin
            w_spec_nv = 1'b1;
        end else if ((w_cls_a[1] | w_cls_b[1]) & w_cls_c[1] & (w_c[PARM_XLEN-1] != w_sign_p)) begin
            w_spec_nv = 1'b1;
        end else if (w_cls_a[1] | w_cls_b[1]) begin
            w_spec_res = {w_sign_p, {PARM_EXP{1'b1}}, {PARM_MANT{1'b0}}};
        end else if (w_cls_c[1]) begin
            w_spec_res = w_c;
        end else begin
            w_special = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr       <= 1'b0;
            r_dp_valid <= 1'b0;
        end else begin
            if (w_accept) r_rr <= ~w_sel;
            r_dp_valid <= w_accept & ~w_special;
        end
        if (w_accept) begin
            r_dp_a <= w_a;
            r_dp_b <= w_b;
            r_dp_c <= w_c;
        end
    end

    assign dp_valid_o = r_dp_valid;
    assign dp_A_o     = r_dp_a;
    assign dp_B_o     = r_dp_b;
    assign dp_C_o     = r_dp_c;

    // Every accepted op takes a slot so specials stay ordered behind datapath ops.
    always_ff @(posedge clk_i) begin
        if (rst_i) r_dl_valid <= '0;
        else       r_dl_valid <= {r_dl_valid[DL-1:0], w_accept};
        r_dl_special <= {r_dl_special[DL-1:0], w_special};
        r_dl_nv      <= {r_dl_nv[DL-1:0], w_spec_nv & w_special};
        r_dl_src     <= {r_dl_src[DL-1:0], w_sel};
        r_dl_res[0]  <= w_spec_res;
        r_dl_tag[0]  <= w_tag;
        for (int k = 1; k <= DL; k++) begin
            r_dl_res[k] <= r_dl_res[k-1];
            r_dl_tag[k] <= r_dl_tag[k-1];
        end
    end

    assign w_fifo_wr   = r_dl_valid[DL];
    assign w_fifo_data = r_dl_special[DL] ? r_dl_res[DL] : dp_result_i;
    assign res_valid_o = (r_fifo_cnt != '0);
    assign w_pop       = res_valid_o & res_ready_i;

    always_ff @(posedge clk_i) begin
        if (w_fifo_wr) begin
            r_mem_data[r_wr_ptr] <= w_fifo_data;
            r_mem_tag[r_wr_ptr]  <= r_dl_tag[DL];
            r_mem_src[r_wr_ptr]  <= r_dl_src[DL];
            r_mem_nv[r_wr_ptr]   <= r_dl_nv[DL];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
            r_occ      <= '0;
        end else begin
            if (w_fifo_wr) r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_ONE;
            if (w_pop)     r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_ONE;
            case ({w_fifo_wr, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + OCC_ONE;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - OCC_ONE;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
            case ({w_accept, w_pop})
                2'b10:   r_occ <= r_occ + OCC_ONE;
                2'b01:   r_occ <= r_occ - OCC_ONE;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign res_data_o = r_mem_data[r_rd_ptr];
    assign res_tag_o  = r_mem_tag[r_rd_ptr];
    assign res_src_o  = r_mem_src[r_rd_ptr];
    assign res_nv_o   = res_valid_o & r_mem_nv[r_rd_ptr];
    assign busy_o     = (r_occ != '0);

endmodule

// File: tb/tb_fma_issue_ctrl.sv
// tb/tb_fma_issue_ctrl.sv - directed and random checks of fma_issue_ctrl against a timestamped queue model
module tb_fma_issue_ctrl;
    localparam int LAT   = 4;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_A, req_B, req_C;
    logic [7:0]  req_tag;
    logic        dp_valid;
    logic [31:0] dp_A, dp_B, dp_C;
    logic [31:0] dp_result;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [3:0]  res_tag;
    logic        res_src, res_nv, busy;

    fma_issue_ctrl dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_A_i(req_A), .req_B_i(req_B), .req_C_i(req_C), .req_tag_i(req_tag),
        .dp_valid_o(dp_valid), .dp_A_o(dp_A), .dp_B_o(dp_B), .dp_C_o(dp_C),
        .dp_result_i(dp_result),
        .res_valid_o(res_valid), .res_ready_i(res_ready),
        .res_data_o(res_data), .res_tag_o(res_tag), .res_src_o(res_src),
        .res_nv_o(res_nv), .busy_o(busy)
    );

    // Stand-in datapath: 1*2+3=5 for the documented vector, a scramble otherwise.
    function automatic logic [31:0] dp_func(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        if (a == 32'h3F800000 && b == 32'h40000000 && c == 32'h40400000) return 32'h40A00000;
        return (a ^ {b[15:0], b[31:16]}) + c;
    endfunction

    logic [31:0] dpp [0:LAT-1];
    always @(posedge clk) begin
        dpp[0] <= dp_valid ? dp_func(dp_A, dp_B, dp_C) : 32'hDEADBEEF;
        for (int k = 1; k < LAT; k++) dpp[k] <= dpp[k-1];
    end
    assign dp_result = dpp[LAT-1];

    function automatic logic is_nan(input logic [31:0] x);
        return x[30:23] == 8'hFF && x[22:0] != 23'd0;
    endfunction
    function automatic logic is_snan(input logic [31:0] x);
        return is_nan(x) && !x[22];
    endfunction
    function automatic logic is_inf(input logic [31:0] x);
        return x[30:23] == 8'hFF && x[22:0] == 23'd0;
    endfunction
    function automatic logic is_zero(input logic [31:0] x);
        return x[30:0] == 31'd0;
    endfunction

    function automatic void ref_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                                   output logic sp, output logic [31:0] r, output logic nv);
        logic ps;
        ps = a[31] ^ b[31];
        sp = 1'b1; r = 32'h7FC00000; nv = 1'b0;
        if (is_nan(a) || is_nan(b) || is_nan(c)) nv = is_snan(a) || is_snan(b) || is_snan(c);
        else if ((is_inf(a) && is_zero(b)) || (is_zero(a) && is_inf(b))) nv = 1'b1;
        else if ((is_inf(a) || is_inf(b)) && is_inf(c) && c[31] != ps) nv = 1'b1;
        else if (is_inf(a) || is_inf(b)) r = ps ? 32'hFF800000 : 32'h7F800000;
        else if (is_inf(c)) r = c;
        else sp = 1'b0;
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 15))
            0: return 32'h00000000;
            1: return 32'h80000000;
            2: return 32'h7F800000;
            3: return 32'hFF800000;
            4: return {r[31], 8'hFF, 1'b1, r[21:0]};
            5: return {r[31], 8'hFF, 1'b0, r[21:1], 1'b1};
            6: return {r[31], 8'h00, r[22:0]};
            default: return {r[31], 8'h40 + {1'b0, r[29:23]}, r[22:0]};
        endcase
    endfunction

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  tag;
        logic        src;
        logic        nv;
        int          vis;
    } exp_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          obs_acc = 0;
    logic        rr_m = 1'b0;
    int          occ_m = 0;
    exp_t        q[$];
    logic        dpx_v = 1'b0;
    logic [31:0] dpx_a, dpx_b, dpx_c;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        logic [1:0]  g, rdy;
        logic        rv, acc, pop, w, sp, nv;
        logic [31:0] a, b, c, sr;
        exp_t        e;
        #1;
        case (req_valid)
            2'b01:   g = 2'b01;
            2'b10:   g = 2'b10;
            2'b11:   g = rr_m ? 2'b10 : 2'b01;
            default: g = 2'b00;
        endcase
        rdy = (!rst && occ_m < DEPTH) ? g : 2'b00;
        chk("req_ready", {30'd0, req_ready}, {30'd0, rdy});
        if (|(req_valid & req_ready)) obs_acc++;
        rv = 1'b0;
        if (!rst) begin
            rv = (q.size() > 0) && (q[0].vis <= cyc);
            chk("busy", {31'd0, busy}, {31'd0, occ_m != 0});
            chk("res_valid", {31'd0, res_valid}, {31'd0, rv});
            chk("dp_valid", {31'd0, dp_valid}, {31'd0, dpx_v});
            if (rv) begin
                chk("res_data", res_data, q[0].data);
                chk("res_tag", {28'd0, res_tag}, {28'd0, q[0].tag});
                chk("res_src", {31'd0, res_src}, {31'd0, q[0].src});
                chk("res_nv", {31'd0, res_nv}, {31'd0, q[0].nv});
            end else begin
                chk("res_nv_idle", {31'd0, res_nv}, 32'd0);
            end
            if (dpx_v) begin
                chk("dp_A", dp_A, dpx_a);
                chk("dp_B", dp_B, dpx_b);
                chk("dp_C", dp_C, dpx_c);
            end
        end
        acc = |(req_valid & rdy);
        pop = rv & res_ready;
        dpx_v = 1'b0;
        if (rst) begin
            q.delete();
            occ_m = 0;
            rr_m = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) begin
                w = g[1];
                a = w ? req_A[63:32] : req_A[31:0];
                b = w ? req_B[63:32] : req_B[31:0];
                c = w ? req_C[63:32] : req_C[31:0];
                ref_op(a, b, c, sp, sr, nv);
                e.data = sp ? sr : dp_func(a, b, c);
                e.tag  = w ? req_tag[7:4] : req_tag[3:0];
                e.src  = w;
                e.nv   = nv;
                e.vis  = cyc + LAT + 2;
                q.push_back(e);
                rr_m  = ~w;
                dpx_v = !sp;
                dpx_a = a; dpx_b = b; dpx_c = c;
            end
            occ_m = occ_m + int'(acc) - int'(pop);
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic drive(input logic [1:0] v,
                         input logic [31:0] a0, input logic [31:0] b0, input logic [31:0] c0, input logic [3:0] t0,
                         input logic [31:0] a1, input logic [31:0] b1, input logic [31:0] c1, input logic [3:0] t1,
                         input logic rdy_in, input logic rs);
        @(negedge clk);
        rst = rs;
        req_valid = v;
        req_A = {a1, a0}; req_B = {b1, b0}; req_C = {c1, c0};
        req_tag = {t1, t0};
        res_ready = rdy_in;
        step();
    endtask

    task automatic drive_rand(input logic [1:0] v, input logic rdy_in);
        drive(v, rnd_op(), rnd_op(), rnd_op(), 4'($urandom_range(0, 15)),
              rnd_op(), rnd_op(), rnd_op(), 4'($urandom_range(0, 15)), rdy_in, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b1; req_valid = 2'b00; req_A = '0; req_B = '0; req_C = '0; req_tag = '0; res_ready = 1'b1;
        drive(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b1);
        drive(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b1);

        drive(2'b01, 32'h3F800000, 32'h40000000, 32'h40400000, 4'd3, 0, 0, 0, 0, 1'b1, 1'b0);
        idle(8);

        drive(2'b01, 32'h3F800000, 32'h40000000, 32'h40400000, 4'd1, 0, 0, 0, 0, 1'b1, 1'b0);
        drive(2'b10, 0, 0, 0, 0, 32'h7F800000, 32'h00000000, 32'h3F800000, 4'd5, 1'b1, 1'b0);
        idle(8);

        drive(2'b01, 32'h7F800001, 32'h3F800000, 32'h3F800000, 4'd6, 0, 0, 0, 0, 1'b1, 1'b0);
        drive(2'b01, 32'h7FC00001, 32'h3F800000, 32'h3F800000, 4'd7, 0, 0, 0, 0, 1'b1, 1'b0);
        drive(2'b01, 32'h7F800000, 32'h3F800000, 32'hFF800000, 4'd8, 0, 0, 0, 0, 1'b1, 1'b0);
        drive(2'b01, 32'hFF800000, 32'h3F800000, 32'h3F800000, 4'd9, 0, 0, 0, 0, 1'b1, 1'b0);
        drive(2'b01, 32'h3F800000, 32'h3F800000, 32'h7F800000, 4'd10, 0, 0, 0, 0, 1'b1, 1'b0);
        idle(8);

        for (int i = 0; i < 10; i++) drive_rand(2'b11, 1'b1);
        idle(8);

        obs_acc = 0;
        for (int i = 0; i < 12; i++) drive_rand(2'b11, 1'b0);
        chk("stall_accepts", obs_acc, 32'd8);
        #1;
        chk("stall_busy", {31'd0, busy}, 32'd1);
        chk("stall_ready", {30'd0, req_ready}, 32'd0);
        for (int i = 0; i < 14; i++) drive_rand(2'b11, 1'b1);
        idle(14);

        for (int i = 0; i < 1500; i++) drive_rand(2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
        idle(20);

        for (int i = 0; i < 3; i++) drive_rand(2'b01, 1'b1);
        drive(2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b1);
        #1;
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_dp_valid", {31'd0, dp_valid}, 32'd0);
        idle(12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
